// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with 3-sample majority voting,
// false-start rejection, framing/parity error flags and a valid/ready output
// that drops (and flags) a completed frame rather than overwrite a held word.
// Optional feature macro: UART_RX_PARITY_EN (builds the parity bit check).
module uart_rx_frame #(
  parameter int unsigned CLK_PER_BIT = 434,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned CW   = $clog2(CLK_PER_BIT);
  localparam int unsigned HALF = CLK_PER_BIT >> 1;
  localparam int unsigned BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] SAMPLE_A = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMPLE_B = CW'(HALF);
  localparam logic [CW-1:0] SAMPLE_V = CW'(HALF + 1);
  localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);

  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  // Reject configurations the sampling scheme cannot support
  if (CLK_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_frame: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        ctr;
  logic [BW-1:0]        bit_cnt;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic                 at_a;
  logic                 at_b;
  logic                 at_vote;
  logic                 wrap;
  logic                 complete;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_pend;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic            parity_pend;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign at_a    = (ctr == SAMPLE_A);
  assign at_b    = (ctr == SAMPLE_B);
  assign at_vote = (ctr == SAMPLE_V);
  assign wrap    = (ctr == CTR_LAST);
  // Third sample is taken live at the vote cycle
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Capture the first two of the three mid-bit samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (at_a) samp_a <= rx_s;
      if (at_b) samp_b <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and frame-completion strobe
  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        if (at_vote && vote) state_next = IDLE;
        else if (wrap)       state_next = DATA;
      end
      DATA: begin
        if (wrap && (bit_cnt == DATA_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (wrap) state_next = STOP;
      end
`endif
      STOP: begin
        // Leave at the last stop vote so the next start edge is never missed
        if (at_vote && (bit_cnt == STOP_LAST)) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit-period counter: held at 0 in IDLE so START begins at ctr=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
    end else if (state == IDLE || state_next == IDLE || wrap) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + 1'b1;
    end
  end

  // Vote counter for data and stop bits, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state_next != state) begin
      bit_cnt <= '0;
    end else if (at_vote && (state == DATA || state == STOP)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Shift register and pending error flags for the frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      frame_pend  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_pend <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        frame_pend  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_pend <= 1'b0;
`endif
      end
      if (state == DATA && at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && at_vote) parity_pend <= (^shreg) ^ vote ^ PAR_SENSE;
`endif
      if (state == STOP && at_vote && !vote) frame_pend <= 1'b1;
    end
  end

  // Output word register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!valid || ready) begin
          data       <= shreg;
          // Last stop vote is folded in here since it is not yet in frame_pend
          frame_err  <= frame_pend | ~vote;
`ifdef UART_RX_PARITY_EN
          parity_err <= parity_pend;
`endif
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table-driven, hand-sequenced and randomized checks of
// uart_rx_frame at CLK_PER_BIT=16, 8 data bits, 1 stop bit, even parity.
module tb_uart_rx_frame;

  localparam int unsigned CPB  = 16;
  localparam int unsigned DB   = 8;
  localparam int unsigned SB   = 1;
  localparam int unsigned PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PBITS  = 1;
  localparam logic        PE_EXP = 1'b1;
`else
  localparam int unsigned PBITS  = 0;
  localparam logic        PE_EXP = 1'b0;
`endif
  // rx edge -> valid, counted in negedges: 2 sync + 1 idle detect + frame
  localparam int LAT = 3 + (1 + DB + PBITS + SB - 1) * CPB + CPB / 2 + 2;
  localparam int NRAND = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks   = 0;
  int errors   = 0;
  int ov_count = 0;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } word_t;

  uart_rx_frame #(
    .CLK_PER_BIT(CPB),
    .DATA_BITS  (DB),
    .STOP_BITS  (SB),
    .PARITY_ODD (PODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what a frame should deliver, straight from the line encoding
  function automatic word_t model(input logic [7:0] d, input logic par, input logic stop);
    word_t w;
    w.d  = d;
    w.fe = !stop;
    if (PBITS != 0) w.pe = (($countones(d) + int'(par)) % 2) != int'(PODD);
    else            w.pe = 1'b0;
    return w;
  endfunction

  // Drive one frame, one bit per CPB clocks; must be entered just after a negedge
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int gap_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PBITS != 0) begin
      rx = par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  task automatic wait_word(input int limit, output word_t w, output int cyc, output bit ok);
    ok   = 1'b0;
    cyc  = 0;
    w.d  = '0;
    w.fe = 1'b0;
    w.pe = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cyc++;
      if (valid && ready) begin
        w.d  = data;
        w.fe = frame_err;
        w.pe = parity_err;
        ok   = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
    @(negedge clk);
  endtask

  // Held word must not move while stalled; overrun must be a single-cycle pulse
  logic       pv, pr, pfe, ppe, pov;
  logic [7:0] pd;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv  = 1'b0;
      pov = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || data !== pd || frame_err !== pfe || parity_err !== ppe) begin
          errors++;
          $display("FAIL hold: got valid=%b data=%h fe=%b pe=%b expected valid=1 data=%h fe=%b pe=%b",
                   valid, data, frame_err, parity_err, pd, pfe, ppe);
        end
      end
      if (overrun) begin
        ov_count++;
        checks++;
        if (pov) begin
          errors++;
          $display("FAIL overrun_width: got 2+ cycle pulse expected 1 cycle");
        end
      end
      pv  = valid;
      pr  = ready;
      pd  = data;
      pfe = frame_err;
      ppe = parity_err;
      pov = overrun;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t       tbl[9];
  word_t      w;
  word_t      exp_q[$];
  int         cyc;
  bit         ok;
  logic       vlow;
  int         ov_base;
  logic [7:0] rd[NRAND];
  logic       rp[NRAND];
  logic       rs[NRAND];
  int         rg[NRAND];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[5] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b0, PE_EXP};
    tbl[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[8] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Table: each frame followed by 2 idle bits, ready held high
    for (int i = 0; i < 9; i++) begin
      fork
        send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 2);
        begin
          wait_word(LAT + CPB, w, cyc, ok);
          @(negedge clk);
          vlow = valid;
        end
      join
      check($sformatf("tbl%0d_received", i), ok, 1'b1);
      check($sformatf("tbl%0d_data", i), w.d, tbl[i].exp_d);
      check($sformatf("tbl%0d_frame_err", i), w.fe, tbl[i].exp_fe);
      check($sformatf("tbl%0d_parity_err", i), w.pe, tbl[i].exp_pe);
      check($sformatf("tbl%0d_latency", i), cyc, LAT);
      check($sformatf("tbl%0d_valid_pulse", i), vlow, 1'b0);
    end

    // False start: 5-cycle glitch, then a clean frame
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    vlow = 1'b0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (valid) vlow = 1'b1;
    end
    check("glitch_no_valid", vlow, 1'b0);
    fork
      send_frame(8'h3C, 1'b0, 1'b1, 2);
      wait_word(LAT + CPB, w, cyc, ok);
    join
    check("glitch_next_received", ok, 1'b1);
    check("glitch_next_data", w.d, 8'h3C);
    check("glitch_next_latency", cyc, LAT);

    // Overrun: two back-to-back frames with the consumer stalled
    set_ready(1'b0);
    ov_base = ov_count;
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 2);
    check("ovr_valid_held", valid, 1'b1);
    check("ovr_data_held", data, 8'h11);
    check("ovr_pulse_count", ov_count - ov_base, 1);
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    check("ovr_accept_valid", valid, 1'b1);
    check("ovr_accept_data", data, 8'h11);
    @(negedge clk);
    check("ovr_valid_drop", valid, 1'b0);

    // Reset during data bit 4 with a word already held
    set_ready(1'b0);
    send_frame(8'h99, 1'b0, 1'b1, 1);
    check("rst_pre_valid", valid, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_valid", valid, 1'b0);
    check("rst_mid_frame_err", frame_err, 1'b0);
    check("rst_mid_parity_err", parity_err, 1'b0);
    check("rst_mid_overrun", overrun, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    repeat (2 * CPB) @(negedge clk);
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 2);
      wait_word(LAT + CPB, w, cyc, ok);
    join
    check("rst_after_received", ok, 1'b1);
    check("rst_after_data", w.d, 8'h5A);
    check("rst_after_frame_err", w.fe, 1'b0);

    // Random frames: back-to-back when the stop bit is good
    for (int k = 0; k < NRAND; k++) begin
      rd[k] = 8'($urandom_range(0, 255));
      rs[k] = ($urandom_range(0, 3) != 0);
      rp[k] = (^rd[k]) ^ (PODD != 0) ^ ($urandom_range(0, 3) == 0);
      rg[k] = rs[k] ? 0 : 2;
      if (k == NRAND - 1) rg[k] = 2;
      exp_q.push_back(model(rd[k], rp[k], rs[k]));
    end
    fork
      begin
        for (int k = 0; k < NRAND; k++) send_frame(rd[k], rp[k], rs[k], rg[k]);
      end
      begin
        for (int j = 0; j < NRAND; j++) begin
          wait_word(LAT + 4 * CPB, w, cyc, ok);
          check($sformatf("rand%0d_received", j), ok, 1'b1);
          if (!ok) break;
          check($sformatf("rand%0d_data", j), w.d, exp_q[j].d);
          check($sformatf("rand%0d_frame_err", j), w.fe, exp_q[j].fe);
          check($sformatf("rand%0d_parity_err", j), w.pe, exp_q[j].pe);
        end
      end
    join
    check("no_stray_overrun", ov_count - ov_base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that supersedes the fixed 8N1 byte receiver. It adds configurable data width and stop bits, 3-sample majority voting, false-start rejection, framing/parity error flags and an overrun-safe valid/ready output. It sits between the board RX pin and any byte/word consumer, such as a command parser or FIFO.

## Interface
- `CLK_PER_BIT`, 434 — clocks per bit; 434 gives 115200 baud at 50 MHz; minimum 8.
- `DATA_BITS`, 8 — data bits per frame, 5..9, LSB first.
- `STOP_BITS`, 1 — stop bits checked, 1 or 2.
- `PARITY_ODD`, 0 — 0 selects even parity, 1 selects odd; used only with `UART_RX_PARITY_EN`.
- `clk`  in  1  — system clock; single clock domain.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `rx`  in  1  — asynchronous serial input; idles high.
- `data`  out  DATA_BITS  — received word; stable while `valid`=1.
- `valid`  out  1  — word available.
- `ready`  in  1  — consumer accepts the word when `valid`&&`ready`.
- `frame_err`  out  1  — qualifies `data`: a stop bit was sampled low.
- `parity_err`  out  1  — qualifies `data`: parity mismatch; tied 0 without the macro.
- `overrun`  out  1  — one-cycle pulse: a completed frame was dropped.

## Operation
- `rx` passes through a 2-flop synchronizer into `rx_s`. Both flops reset to 1.
- The bit counter `ctr` is `$clog2(CLK_PER_BIT)` bits wide and counts 0..CLK_PER_BIT-1 within each bit, then wraps to 0.
- `HALF` = CLK_PER_BIT>>1.
- Samples are taken at `ctr`==HALF-1, HALF and HALF+1. The bit value is the majority (2 of 3), decided at HALF+1.
- State machine:
  - `IDLE`: `ctr` is cleared. If `rx_s`==0, go to `START`.
  - `START`: at the vote, if the majority is 1 it is a false start; go to `IDLE`. Otherwise continue counting. At wrap, go to `DATA`.
  - `DATA`: on each vote, shift the bit into the MSB of the shift register. After DATA_BITS votes, at wrap, go to `PARITY` (macro defined) or `STOP`.
  - `PARITY`: the vote is XORed with the data bits. Mismatch against the selected parity sets a pending parity error. At wrap, go to `STOP`.
  - `STOP`: each stop vote that is 0 sets a pending frame error. After the vote of the last stop bit, go to `IDLE` immediately and complete the frame. The receiver does not wait out the rest of the stop bit, so it resynchronises on the next edge.
- Frame completion:
  - If `valid`==0 or `ready`==1 in that cycle, load `data`, `frame_err` and `parity_err`, and set `valid`.
  - Otherwise keep the old word, discard the new one and pulse `overrun`.
- Handshake:
  - `valid` clears the cycle after `valid`&&`ready`, unless a completion loads a new word in the same cycle. In that case `valid` stays 1 with the new `data`.
  - `data` and the error flags never change while `valid`=1 and `ready`=0.
- A framing error still delivers the word with `frame_err`=1. No break detection is performed: a held-low line re-enters `START` after `IDLE`.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, state `IDLE`, `ctr`=0.
- Input latency: 2 cycles for synchronization, plus 1 cycle in `IDLE` to detect the start.
- `valid` rises 1 cycle after the last stop vote. That is (1+DATA_BITS+P+STOP_BITS-1)·CLK_PER_BIT + HALF+2 cycles after `START` entry, where P=1 with the macro and 0 without.
- `overrun` is exactly 1 cycle wide, in the cycle after the dropped completion.
- Reset asserted mid-frame aborts the frame immediately. After release, reception begins only on a fresh low level in `IDLE`.
- Throughput: frames arrive back-to-back with a 1-bit stop, and there is no lost start edge.

## Configuration
- `UART_RX_PARITY_EN` defined: the `PARITY` state and comparator are built. Frames carry one parity bit, selected by `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined: no parity bit is expected, the `PARITY` state is absent and `parity_err` is constant 0.

## Test plan
- CLK_PER_BIT=16, 8N1, `ready`=1. Send 0xA5 → `valid` pulses for 1 cycle with `data`=0xA5 and `frame_err`=0.
- A 5-cycle low glitch on `rx` while idle → no `valid`; the receiver returns to `IDLE`, then the following 0x3C is received correctly.
- Stop bit driven low for 0x81 → `data`=0x81, `frame_err`=1. The next frame 0x00 → `frame_err`=0.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0: send 0x07 with parity 1 → `parity_err`=0. Send 0x07 with parity 0 → `parity_err`=1.
- `ready`=0, send 0x11 then 0x22 → `data` stays 0x11 and `overrun` pulses once at 0x22 completion. Raise `ready` → `valid` drops the next cycle.
- Assert `rst_n`=0 during data bit 4 of a frame → all outputs return to reset values within 0 cycles of assertion. A clean 0x5A sent after release is received.
